// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute controller: fetches one instruction word,
// decodes its class and immediate, and sequences the EXEC/MEM/WB strobes.
module fetch_decode_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        zero,
  output logic [2:0]  estado,
  output logic        pcsrc,
  output logic [11:0] immediate,
  output logic [31:0] instr,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  typedef enum logic [2:0] {
    PC_UPD = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    IFETCH = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    K_RALU  = 3'd0,
    K_IALU  = 3'd1,
    K_LOAD  = 3'd2,
    K_STORE = 3'd3,
    K_BEQ   = 3'd4,
    K_BNE   = 3'd5,
    K_ILL   = 3'd6
  } kind_t;

  state_t      state;
  kind_t       kind;
  kind_t       dec_kind;
  logic [11:0] dec_imm;

  assign estado = state;

  // Instruction class and immediate, taken straight from the IR.
  always_comb begin
    dec_kind = K_ILL;
    dec_imm  = '0;
    case (instr[6:0])
      7'b0110011: dec_kind = K_RALU;
      7'b0010011: begin
        dec_kind = K_IALU;
        dec_imm  = instr[31:20];
      end
      7'b0000011: begin
        dec_kind = K_LOAD;
        dec_imm  = instr[31:20];
      end
      7'b0100011: begin
        dec_kind = K_STORE;
        dec_imm  = {instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        if (instr[14:12] == 3'b000 || instr[14:12] == 3'b001) begin
          dec_kind = (instr[14:12] == 3'b000) ? K_BEQ : K_BNE;
          dec_imm  = {instr[31], instr[7], instr[30:25], instr[11:8]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IFETCH;
      kind      <= K_ILL;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      instr     <= '0;
      immediate <= '0;
      pcsrc     <= 1'b0;
      illegal   <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      // Strobes are one-cycle pulses; only the entering transition raises them.
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IFETCH: begin
          // req low in IFETCH means no request is outstanding yet.
          if (!imem_req) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
          end else if (imem_ready) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          kind      <= dec_kind;
          immediate <= dec_imm;
          if (dec_kind == K_ILL) begin
            illegal <= 1'b1;
            pcsrc   <= 1'b0;
            state   <= PC_UPD;
          end else begin
            illegal <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          case (kind)
            K_RALU, K_IALU: begin
              reg_write <= 1'b1;
              state     <= WB;
            end
            K_LOAD: begin
              mem_read <= 1'b1;
              state    <= MEM;
            end
            K_STORE: begin
              mem_write <= 1'b1;
              state     <= MEM;
            end
            K_BEQ: begin
              pcsrc <= zero;
              state <= PC_UPD;
            end
            K_BNE: begin
              pcsrc <= ~zero;
              state <= PC_UPD;
            end
            default: state <= PC_UPD;
          endcase
        end
        MEM: begin
          if (kind == K_LOAD) begin
            reg_write <= 1'b1;
            state     <= WB;
          end else begin
            state <= PC_UPD;
          end
        end
        WB: state <= PC_UPD;
        PC_UPD: begin
          pcsrc <= 1'b0;
          state <= IFETCH;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IFETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: walks each instruction class through
// its state sequence and exercises reset mid-fetch and mid-MEM.
module tb_fetch_decode_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        zero;
  logic [2:0]  estado;
  logic        pcsrc;
  logic [11:0] immediate;
  logic [31:0] instr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        illegal;

  int n_checks;
  int n_fail;

  // Expected state walks after IFETCH, first state in the low 3 bits.
  localparam logic [23:0] SEQ_ALU = {9'd0, 3'b101, 3'b000, 3'b100, 3'b010, 3'b001};
  localparam logic [23:0] SEQ_BR  = {12'd0, 3'b101, 3'b000, 3'b010, 3'b001};
  localparam logic [23:0] SEQ_LD  = {6'd0, 3'b101, 3'b000, 3'b100, 3'b011, 3'b010, 3'b001};
  localparam logic [23:0] SEQ_ST  = {9'd0, 3'b101, 3'b000, 3'b011, 3'b010, 3'b001};
  localparam logic [23:0] SEQ_ILL = {15'd0, 3'b101, 3'b000, 3'b001};

  fetch_decode_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .zero       (zero),
    .estado     (estado),
    .pcsrc      (pcsrc),
    .immediate  (immediate),
    .instr      (instr),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input string what,
                             input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s: observed %0h expected %0h", name, what, obs, exp);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput(name, "estado",    32'(estado),    32'h5);
    checkOutput(name, "imem_req",  32'(imem_req),  32'h0);
    checkOutput(name, "imem_addr", imem_addr,      32'h0);
    checkOutput(name, "instr",     instr,          32'h0);
    checkOutput(name, "immediate", 32'(immediate), 32'h0);
    checkOutput(name, "pcsrc",     32'(pcsrc),     32'h0);
    checkOutput(name, "illegal",   32'(illegal),   32'h0);
    checkOutput(name, "reg_write", 32'(reg_write), 32'h0);
    checkOutput(name, "mem_read",  32'(mem_read),  32'h0);
    checkOutput(name, "mem_write", 32'(mem_write), 32'h0);
  endtask

  // Starts at a negedge in IFETCH with no request out; ends at the DECODE negedge.
  task automatic fetchOnly(input string name, input logic [31:0] p, input logic [31:0] d,
                           input int delay, input logic stale);
    pc         = p;
    imem_ready = stale;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput(name, "fetch_estado", 32'(estado),   32'h5);
    checkOutput(name, "req_up",       32'(imem_req), 32'h1);
    checkOutput(name, "addr",         imem_addr,     p);
    if (stale) checkOutput(name, "stale_ir", instr, 32'h0);
    imem_ready = 1'b0;
    pc         = ~p;
    repeat (delay) begin
      @(negedge clk);
      checkOutput(name, "req_hold",  32'(imem_req), 32'h1);
      checkOutput(name, "addr_hold", imem_addr,     p);
    end
    imem_ready = 1'b1;
    imem_rdata = d;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    checkOutput(name, "req_drop", 32'(imem_req), 32'h0);
    checkOutput(name, "ir",       instr,         d);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] p, input logic [31:0] d,
                               input int delay, input logic z, input logic [23:0] seq,
                               input int len, input logic [11:0] exp_imm, input logic exp_pcsrc,
                               input logic exp_ill, input logic exp_load, input logic stale);
    logic [2:0] s;
    fetchOnly(name, p, d, delay, stale);
    for (int i = 0; i < len; i++) begin
      s = seq[3*i +: 3];
      if (i == 0) zero = ~z;
      if (s == 3'b010) zero = z;
      checkOutput(name, $sformatf("estado%0d", i), 32'(estado), 32'(s));
      checkOutput(name, "reg_write", 32'(reg_write), 32'(s == 3'b100));
      checkOutput(name, "mem_read",  32'(mem_read),  32'(s == 3'b011 && exp_load));
      checkOutput(name, "mem_write", 32'(mem_write), 32'(s == 3'b011 && !exp_load));
      if (i > 0) begin
        checkOutput(name, "immediate", 32'(immediate), 32'(exp_imm));
        checkOutput(name, "illegal",   32'(illegal),   32'(exp_ill));
      end
      if (s == 3'b000) checkOutput(name, "pcsrc_upd", 32'(pcsrc), 32'(exp_pcsrc));
      if (i < len - 1) @(negedge clk);
    end
    checkOutput(name, "pcsrc_fetch", 32'(pcsrc),    32'h0);
    checkOutput(name, "req_idle",    32'(imem_req), 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    pc         = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    zero       = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("por");
    reset = 1'b0;

    applyStimulus("addi",   32'd0, 32'h0050_0093, 2, 1'b0, SEQ_ALU, 5, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("beq_t",  32'd1, 32'h0020_8463, 0, 1'b1, SEQ_BR,  4, 12'h004, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("beq_nt", 32'd2, 32'h0020_8463, 1, 1'b0, SEQ_BR,  4, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bne_t",  32'd3, 32'h0020_9463, 0, 1'b0, SEQ_BR,  4, 12'h004, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("lw",     32'd4, 32'h0040_A103, 1, 1'b0, SEQ_LD,  6, 12'h004, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("sw",     32'd5, 32'h0020_A223, 3, 1'b0, SEQ_ST,  5, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ill",    32'd6, 32'h0000_007F, 0, 1'b1, SEQ_ILL, 3, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("br_f3",  32'd7, 32'h0020_A463, 0, 1'b1, SEQ_ILL, 3, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("addi2",  32'd8, 32'h0050_0093, 0, 1'b0, SEQ_ALU, 5, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while a request is outstanding, with a response arriving in the reset cycle.
    pc = 32'd9;
    @(negedge clk);
    checkOutput("rst_fetch", "req_up", 32'(imem_req), 32'h1);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkReset("rst_fetch");
    reset = 1'b0;
    applyStimulus("after_rst", 32'd10, 32'h0050_0093, 1, 1'b0, SEQ_ALU, 5, 12'h005, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a load's MEM cycle.
    fetchOnly("lw_rst", 32'd11, 32'h0040_A103, 0, 1'b0);
    @(negedge clk);
    checkOutput("lw_rst", "estado_exec", 32'(estado), 32'h2);
    @(negedge clk);
    checkOutput("lw_rst", "estado_mem", 32'(estado),   32'h3);
    checkOutput("lw_rst", "mem_read",   32'(mem_read), 32'h1);
    reset      = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    checkReset("rst_mem");
    reset      = 1'b0;
    imem_ready = 1'b0;
    applyStimulus("sw_end", 32'd12, 32'h0020_A223, 0, 1'b0, SEQ_ST, 5, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
